rr_grant_encoder: RTL and testbench

- Round-robin arbiter for a NoC output port: N requesters, one-hot grant plus registered binary grant index.
- Grant is locked for a whole packet and released on the accepted tail flit.
- Sits between input-port request vectors and the output-port crossbar select; grant_idx drives the crossbar mux directly.
- Index encoding is selectable: LSB0 or MSB0.

---
 rtl/noc_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 41 ++++
 rtl/rr_grant_encoder.sv | 96 +++++++++
 tb/tb_rr_grant_encoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiter: index direction names
// and the grant FSM state encoding.
package noc_arb_pkg;

    localparam string DIR_LSB0 = "LSB0";
    localparam string DIR_MSB0 = "MSB0";

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first unmasked request at or above ptr,
// wrapping at NUM_SIGNALS, found by searching a doubled request vector.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_SIGNALS = 4,
    parameter int unsigned PTR_WIDTH   = 2
) (
    input  logic [NUM_SIGNALS-1:0] i_request,
    input  logic [PTR_WIDTH-1:0]   i_ptr,
    input  logic [NUM_SIGNALS-1:0] i_mask,
    output logic [NUM_SIGNALS-1:0] o_oh_c,
    output logic                   o_any_c,
    output logic [PTR_WIDTH-1:0]   o_pos_c
);

    localparam int unsigned DW = 2 * NUM_SIGNALS;

    logic [NUM_SIGNALS-1:0] w_req;
    logic [DW-1:0]          w_dbl;
    logic                   w_hit;

    assign w_req = i_request & ~i_mask;
    // Upper copy supplies the wrapped-around bits below ptr.
    assign w_dbl = {w_req, w_req} & ~((DW'(1) << i_ptr) - DW'(1));

    always_comb begin
        w_hit   = 1'b0;
        o_pos_c = '0;
        for (int unsigned j = 0; j < DW; j++) begin
            if (!w_hit && w_dbl[j]) begin
                w_hit   = 1'b1;
                o_pos_c = (j >= NUM_SIGNALS) ? PTR_WIDTH'(j - NUM_SIGNALS) : PTR_WIDTH'(j);
            end
        end
    end

    assign o_any_c = w_hit;
    assign o_oh_c  = w_hit ? (NUM_SIGNALS'(1) << o_pos_c) : '0;

endmodule

// File: rtl/rr_grant_encoder.sv
// Packet-locked round-robin arbiter for a NoC output port with registered
// one-hot grant and crossbar-select index (LSB0 or MSB0 numbering).
module rr_grant_encoder
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_SIGNALS = 4,
    parameter string       DIRECTION   = "LSB0",
    parameter int unsigned INDEX_WIDTH = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SIGNALS-1:0] request,
    input  logic                   out_ready,
    input  logic                   out_last,
    output logic                   grant_valid,
    output logic [NUM_SIGNALS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0] grant_idx
);

    localparam bit                     IS_MSB0  = (DIRECTION == DIR_MSB0);
    localparam logic [INDEX_WIDTH-1:0] LAST_POS = INDEX_WIDTH'(NUM_SIGNALS - 1);

    arb_state_e             r_state, w_state_nxt;
    logic [INDEX_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic [INDEX_WIDTH-1:0] r_win_pos, w_win_pos_nxt;
    logic [INDEX_WIDTH-1:0] w_idx_nxt, w_rel_ptr, w_pick_ptr, w_pick_pos, w_pick_idx;
    logic [NUM_SIGNALS-1:0] w_oh_nxt, w_pick_oh;
    logic                   w_valid_nxt, w_pick_any, w_transfer, w_release;

    // ptr is always an LSB0 bit position; DIRECTION only affects grant_idx.
    assign w_rel_ptr  = (r_win_pos == LAST_POS) ? '0 : r_win_pos + INDEX_WIDTH'(1);
    assign w_pick_ptr = (r_state == ST_LOCKED) ? w_rel_ptr : r_ptr;
    assign w_pick_idx = IS_MSB0 ? LAST_POS - w_pick_pos : w_pick_pos;

    // Tail acceptance or the grantee dropping its request ends the lock.
    assign w_transfer = grant_valid & out_ready;
    assign w_release  = (w_transfer & out_last) | ~(|(request & grant_oh));

    rr_pick #(
        .NUM_SIGNALS (NUM_SIGNALS),
        .PTR_WIDTH   (INDEX_WIDTH)
    ) u_pick (
        .i_request (request),
        .i_ptr     (w_pick_ptr),
        .i_mask    (grant_oh),
        .o_oh_c    (w_pick_oh),
        .o_any_c   (w_pick_any),
        .o_pos_c   (w_pick_pos)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_pos_nxt = r_win_pos;
        w_valid_nxt   = grant_valid;
        w_oh_nxt      = grant_oh;
        w_idx_nxt     = grant_idx;
        if ((r_state == ST_IDLE) || w_release) begin
            if (r_state == ST_LOCKED) begin
                w_ptr_nxt = w_rel_ptr;
            end
            if (w_pick_any) begin
                w_state_nxt   = ST_LOCKED;
                w_win_pos_nxt = w_pick_pos;
                w_valid_nxt   = 1'b1;
                w_oh_nxt      = w_pick_oh;
                w_idx_nxt     = w_pick_idx;
            end else begin
                w_state_nxt   = ST_IDLE;
                w_win_pos_nxt = '0;
                w_valid_nxt   = 1'b0;
                w_oh_nxt      = '0;
                w_idx_nxt     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_win_pos   <= '0;
            grant_valid <= 1'b0;
            grant_oh    <= '0;
            grant_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_win_pos   <= w_win_pos_nxt;
            grant_valid <= w_valid_nxt;
            grant_oh    <= w_oh_nxt;
            grant_idx   <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: N=4 LSB0, N=4 MSB0 and N=5 MSB0 instances driven
// in parallel and compared against a packet-level round-robin model.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] req5 = '0;
    logic       out_ready = 1'b0;
    logic       out_last = 1'b0;

    logic       gv0, gv1, gv2;
    logic [3:0] goh0, goh1;
    logic [4:0] goh2;
    logic [1:0] gi0, gi1;
    logic [2:0] gi2;

    int checks = 0;
    int failures = 0;

    int m_n   [3] = '{4, 4, 5};
    bit m_msb [3] = '{1'b0, 1'b1, 1'b1};
    int m_g   [3];
    int m_ptr [3];

    always #5 clk = ~clk;

    rr_grant_encoder #(.NUM_SIGNALS(4), .DIRECTION("LSB0")) dut_l4 (
        .clk(clk), .reset_n(reset_n), .request(req5[3:0]), .out_ready(out_ready),
        .out_last(out_last), .grant_valid(gv0), .grant_oh(goh0), .grant_idx(gi0));

    rr_grant_encoder #(.NUM_SIGNALS(4), .DIRECTION("MSB0")) dut_m4 (
        .clk(clk), .reset_n(reset_n), .request(req5[3:0]), .out_ready(out_ready),
        .out_last(out_last), .grant_valid(gv1), .grant_oh(goh1), .grant_idx(gi1));

    rr_grant_encoder #(.NUM_SIGNALS(5), .DIRECTION("MSB0")) dut_m5 (
        .clk(clk), .reset_n(reset_n), .request(req5), .out_ready(out_ready),
        .out_last(out_last), .grant_valid(gv2), .grant_oh(goh2), .grant_idx(gi2));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Invariant: grant is one-hot or zero and grant_valid mirrors it.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ($onehot0(goh0) && $onehot0(goh1) && $onehot0(goh2) &&
                    gv0 == |goh0 && gv1 == |goh1 && gv2 == |goh2) else begin
                failures++;
                $error("FAIL onehot observed=%b/%b/%b expected=onehot0 with matching valid",
                       goh0, goh1, goh2);
            end
        end
    end

    function automatic int pick(input int n, input int req, input int ptr, input int mask);
        for (int o = 0; o < n; o++) begin
            int c;
            c = (ptr + o) % n;
            if (c != mask && req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_g[k]   = -1;
            m_ptr[k] = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int rv;
            rv = (k == 2) ? int'(req5) : int'(req5[3:0]);
            if (m_g[k] < 0) begin
                m_g[k] = pick(m_n[k], rv, m_ptr[k], -1);
            end else if ((out_ready && out_last) || !rv[m_g[k]]) begin
                m_ptr[k] = (m_g[k] + 1) % m_n[k];
                m_g[k]   = pick(m_n[k], rv, m_ptr[k], m_g[k]);
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            int ev, eoh, eidx, ov, ooh, oidx;
            ev   = (m_g[k] >= 0) ? 1 : 0;
            eoh  = (m_g[k] >= 0) ? (1 << m_g[k]) : 0;
            eidx = (m_g[k] < 0) ? 0 : (m_msb[k] ? m_n[k] - 1 - m_g[k] : m_g[k]);
            case (k)
                0:       begin ov = int'(gv0); ooh = int'(goh0); oidx = int'(gi0); end
                1:       begin ov = int'(gv1); ooh = int'(goh1); oidx = int'(gi1); end
                default: begin ov = int'(gv2); ooh = int'(goh2); oidx = int'(gi2); end
            endcase
            chk($sformatf("model_valid[%0d]", k), ov, ev);
            chk($sformatf("model_oh[%0d]", k), ooh, eoh);
            chk($sformatf("model_idx[%0d]", k), oidx, eidx);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic rdy, input logic lst);
        req5      = r;
        out_ready = rdy;
        out_last  = lst;
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

        // Reset state and one-cycle grant latency, then back-to-back handoff.
        do_reset();
        step(5'b00110, 1'b0, 1'b0);
        chk("first_oh", int'(goh0), 4'b0010);
        chk("first_idx", int'(gi0), 1);
        step(5'b00110, 1'b1, 1'b1);
        chk("handoff_oh", int'(goh0), 4'b0100);
        chk("handoff_idx", int'(gi0), 2);
        step(5'b00000, 1'b1, 1'b1);
        chk("to_idle_valid", int'(gv0), 0);

        // Single-flit packets from all requesters rotate 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(5'b01111, 1'b1, 1'b1);
            chk($sformatf("rr_seq_%0d", i), int'(gi0), exp_seq[i]);
        end

        // Three-flit packet from requester 2 with stalls; requester 0 waits.
        do_reset();
        step(5'b00100, 1'b0, 1'b0);
        step(5'b00101, 1'b1, 1'b0);
        step(5'b00101, 1'b0, 1'b0);
        step(5'b00101, 1'b1, 1'b0);
        step(5'b00101, 1'b0, 1'b1);
        chk("pkt_hold_oh", int'(goh0), 4'b0100);
        step(5'b00101, 1'b1, 1'b1);
        chk("pkt_next_oh", int'(goh0), 4'b0001);

        // MSB0 index mapping, including non-power-of-two N.
        do_reset();
        step(5'b00001, 1'b0, 1'b0);
        chk("msb4_oh", int'(goh1), 4'b0001);
        chk("msb4_idx", int'(gi1), 3);
        chk("msb5_idx", int'(gi2), 4);

        // Abort: grantee 1 drops its request without a tail.
        do_reset();
        step(5'b01010, 1'b0, 1'b0);
        chk("abort_pre_idx", int'(gi0), 1);
        step(5'b01000, 1'b0, 1'b0);
        chk("abort_oh", int'(goh0), 4'b1000);
        chk("abort_idx", int'(gi0), 3);
        step(5'b01000, 1'b1, 1'b1);
        chk("abort_rel_valid", int'(gv0), 0);
        step(5'b00011, 1'b0, 1'b0);
        chk("abort_ptr_wrap_idx", int'(gi0), 0);

        // Asynchronous reset in the middle of a packet.
        step(5'b00011, 1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(gv0), 0);
        chk("async_rst_oh", int'(goh0), 0);
        chk("async_rst_idx", int'(gi2), 0);
        model_reset();
        #1 reset_n = 1'b1;
        step(5'b01000, 1'b0, 1'b0);
        chk("post_rst_idx", int'(gi0), 3);
        step(5'b01000, 1'b1, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
